// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver. Synchronizes the raw RX line, times bit
//             centres with a down-counter, assembles bytes LSB-first and
//             buffers them for the CPU. Overrun and framing errors are
//             sticky until clr_err.
//  Config   : UART_RX_FIFO_EN defined   -> 2^FIFODEPTHBITS-entry FIFO
//             UART_RX_FIFO_EN undefined -> single holding register
//  Ports    : clk              system clock
//             power_on_reset_n asynchronous active-low reset
//             rxpin            raw RX line (asynchronous, idle high)
//             rd               pop strobe (ignored while rx_valid=0)
//             clr_err          clears overrun and ferr
//             rx_data          head byte (valid while rx_valid=1)
//             rx_valid         at least one byte buffered
//             overrun          sticky: byte dropped because buffer full
//             ferr             sticky: stop bit sampled low
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
   parameter int CLKDIV        = 260,
   parameter int FIFODEPTHBITS = 2
) (
   input  logic       clk,
   input  logic       power_on_reset_n,
   input  logic       rxpin,
   input  logic       rd,
   input  logic       clr_err,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       overrun,
   output logic       ferr
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   // Half a bit lands the start check mid start-bit; whole bits thereafter.
   localparam logic [15:0] HALF_LOAD = 16'(CLKDIV / 2 - 1);
   localparam logic [15:0] FULL_LOAD = 16'(CLKDIV - 1);

   logic       sync1_q, sync2_q;
   logic       rxs;
   state_t     state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] shift_q, shift_d;
   logic       ferr_q, ferr_d;
   logic       overrun_q, overrun_d;
   logic       push;
   logic       ferr_set;
   logic       overrun_set;
   logic       expired;

   assign rxs     = sync2_q;
   assign expired = (timer_q == 16'd0);

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               timer_d = HALF_LOAD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (!expired) begin
               timer_d = timer_q - 16'd1;
            end else if (rxs) begin
               state_d = S_IDLE;          // glitch: line back high mid start bit
            end else begin
               timer_d  = FULL_LOAD;
               bitcnt_d = 3'd0;
               state_d  = S_DATA;
            end
         end
         S_DATA: begin
            if (!expired) begin
               timer_d = timer_q - 16'd1;
            end else begin
               // Shift in at the MSB so the first (LSB) bit ends in bit 0.
               shift_d  = {rxs, shift_q[7:1]};
               timer_d  = FULL_LOAD;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (!expired) begin
               timer_d = timer_q - 16'd1;
            end else if (rxs) begin
               push    = 1'b1;
               state_d = S_IDLE;
            end else begin
               ferr_set = 1'b1;
               state_d  = S_BREAK;
            end
         end
         S_BREAK: begin
            // Park until the line returns high so a held-low line flags once.
            if (rxs) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- flags
   always_comb begin
      // A set in the same cycle as clr_err wins.
      ferr_d    = ferr_set | (ferr_q & ~clr_err);
      overrun_d = overrun_set | (overrun_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= S_IDLE;
         timer_q   <= 16'd0;
         bitcnt_q  <= 3'd0;
         shift_q   <= 8'd0;
         ferr_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sync1_q   <= rxpin;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         timer_q   <= timer_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         ferr_q    <= ferr_d;
         overrun_q <= overrun_d;
      end
   end

   assign ferr    = ferr_q;
   assign overrun = overrun_q;

   // ---------------------------------------------------------------- buffer
`ifdef UART_RX_FIFO_EN
   localparam int DEPTH = 1 << FIFODEPTHBITS;
   localparam logic [FIFODEPTHBITS:0]   CNT_ONE  = 1;
   localparam logic [FIFODEPTHBITS:0]   CNT_FULL = DEPTH[FIFODEPTHBITS:0];
   localparam logic [FIFODEPTHBITS-1:0] PTR_ONE  = 1;

   logic [7:0]               mem_q [DEPTH];
   logic [7:0]               mem_d [DEPTH];
   logic [FIFODEPTHBITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFODEPTHBITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFODEPTHBITS:0]   count_q, count_d;
   logic                     pop, full, push_ok;

   always_comb begin
      pop         = rd & (count_q != '0);
      full        = (count_q == CNT_FULL);
      // Pop happens before push, so a full buffer being read still accepts.
      push_ok     = push & (~full | pop);
      overrun_set = push & full & ~pop;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = shift_q;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'd0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rx_data  = mem_q[rd_ptr_q];
   assign rx_valid = (count_q != '0);
`else
   logic [7:0] hold_q, hold_d;
   logic       valid_q, valid_d;
   logic       pop, push_ok;

   always_comb begin
      pop         = rd & valid_q;
      push_ok     = push & (~valid_q | pop);
      overrun_set = push & valid_q & ~pop;
      hold_d      = hold_q;
      valid_d     = valid_q;
      if (push_ok) begin
         hold_d  = shift_q;
         valid_d = 1'b1;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         hold_q  <= 8'd0;
         valid_q <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
   end

   assign rx_data  = hold_q;
   assign rx_valid = valid_q;
`endif

endmodule

`default_nettype wire
